// File: rtl/gbuf_b_pingpong_ctrl_pkg.sv
// Shared constants and read-FSM encoding for the Buf-B ping-pong controller.
package gbuf_b_pingpong_ctrl_pkg;

  localparam int unsigned BUF_NUM        = 16;
  localparam int unsigned WORDS_PER_BANK = 32;
  localparam int unsigned ADDR_WIDTH     = 6;
  localparam int unsigned BRAM_DATA_WD   = 128;

  localparam int unsigned BANK_WD    = $clog2(BUF_NUM);
  localparam int unsigned WORD_WD    = $clog2(WORDS_PER_BANK);
  localparam int unsigned HALF_BEATS = BUF_NUM * WORDS_PER_BANK;
  localparam int unsigned WR_CNT_WD  = $clog2(HALF_BEATS);

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    RD_HOLD  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/gbuf_b_pingpong_ctrl_if.sv
// Buf-B read port plus output stream.
//   o_rd_en/o_rd_cs/o_rd_addr/i_rd_data : BRAM read port
//   o_m_valid/o_m_data/i_m_ready         : output stream to next-layer DMA
interface gbuf_b_pingpong_ctrl_if;
  import gbuf_b_pingpong_ctrl_pkg::*;

  logic                    o_rd_en;
  logic [BUF_NUM-1:0]      o_rd_cs;
  logic [ADDR_WIDTH-1:0]   o_rd_addr;
  logic [BRAM_DATA_WD-1:0] i_rd_data;
  logic                    o_m_valid;
  logic [BRAM_DATA_WD-1:0] o_m_data;
  logic                    i_m_ready;

  modport master (
    output o_rd_en, o_rd_cs, o_rd_addr, o_m_valid, o_m_data,
    input  i_rd_data, i_m_ready
  );

  modport slave (
    input  o_rd_en, o_rd_cs, o_rd_addr, o_m_valid, o_m_data,
    output i_rd_data, i_m_ready
  );

endinterface

// File: rtl/gbuf_b_rd_seq.sv
// Bank-major read-out of one full half: issue, wait RD_LAT, hold until accepted.
//   i_clr       : synchronous abort/clear
//   i_half_full : half currently selected for reading is full
//   i_rd_half   : half being read (address MSB)
//   o_done      : last word of the half handed off this cycle
//   o_idle      : FSM in RD_IDLE
module gbuf_b_rd_seq
  import gbuf_b_pingpong_ctrl_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_clr,
  input  logic                  i_half_full,
  input  logic                  i_rd_half,
  output logic                  o_done,
  output logic                  o_idle,
  gbuf_b_pingpong_ctrl_if.master bus
);

  rd_state_e               r_state, nxt_state;
  logic [BANK_WD-1:0]      r_bank;
  logic [WORD_WD-1:0]      r_word;
  logic [1:0]              r_lat_cnt;
  logic                    r_valid;
  logic [BRAM_DATA_WD-1:0] r_data;
  logic                    last_word, lat_done;

  assign last_word = (r_bank == BANK_WD'(BUF_NUM - 1)) &&
                     (r_word == WORD_WD'(WORDS_PER_BANK - 1));
  assign lat_done  = (r_lat_cnt == 2'(RD_LAT - 1));

  assign bus.o_m_valid = r_valid;
  assign bus.o_m_data  = r_data;
  assign o_idle        = (r_state == RD_IDLE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)    r_state <= RD_IDLE;
    else if (i_clr) r_state <= RD_IDLE;
    else            r_state <= nxt_state;
  end

  always_comb begin
    nxt_state     = r_state;
    o_done        = 1'b0;
    bus.o_rd_en   = 1'b0;
    bus.o_rd_cs   = '0;
    bus.o_rd_addr = '0;
    case (r_state)
      RD_IDLE:  if (i_half_full) nxt_state = RD_ISSUE;
      RD_ISSUE: begin
        bus.o_rd_en   = 1'b1;
        bus.o_rd_cs   = BUF_NUM'(1) << r_bank;
        bus.o_rd_addr = {i_rd_half, r_word};
        nxt_state     = RD_WAIT;
      end
      RD_WAIT:  if (lat_done) nxt_state = RD_HOLD;
      RD_HOLD: begin
        if (bus.i_m_ready) begin
          o_done    = last_word;
          nxt_state = last_word ? RD_IDLE : RD_ISSUE;
        end
      end
      default:  nxt_state = RD_IDLE;
    endcase
  end

  // Word/bank roll over to 0/0 by natural wrap after the last word.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_bank    <= '0;
      r_word    <= '0;
      r_lat_cnt <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
    end else if (i_clr) begin
      r_bank    <= '0;
      r_word    <= '0;
      r_lat_cnt <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
    end else begin
      case (r_state)
        RD_ISSUE: r_lat_cnt <= '0;
        RD_WAIT: begin
          r_lat_cnt <= r_lat_cnt + 2'd1;
          if (lat_done) begin
            r_data  <= bus.i_rd_data;
            r_valid <= 1'b1;
          end
        end
        RD_HOLD: begin
          if (bus.i_m_ready) begin
            r_valid <= 1'b0;
            r_word  <= r_word + WORD_WD'(1);
            if (r_word == WORD_WD'(WORDS_PER_BANK - 1)) r_bank <= r_bank + BANK_WD'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gbuf_b_pingpong_ctrl.sv
// Ping-pong scheduler for Global Buffer-B.
//   i_layer_start : synchronous clear of all state
//   i_wr_beat     : one write beat accepted into Buf-B
//   o_wr_half     : half the writer addresses
//   o_wr_stall    : target half still full
//   o_err_ovf     : sticky, beat seen while stalled
//   o_busy        : any half full or reader active
//   m_if          : BRAM read port and output stream
module gbuf_b_pingpong_ctrl
  import gbuf_b_pingpong_ctrl_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_layer_start,
  input  logic                  i_wr_beat,
  output logic                  o_wr_half,
  output logic                  o_wr_stall,
  output logic                  o_err_ovf,
  output logic                  o_busy,
  gbuf_b_pingpong_ctrl_if.master m_if
);

  logic [1:0]           r_full, full_nxt;
  logic                 r_wr_half, r_rd_half, r_err_ovf;
  logic [WR_CNT_WD-1:0] r_wr_cnt;
  logic                 beat_ok, wr_done, rd_done, rd_idle;

  assign o_wr_half  = r_wr_half;
  assign o_wr_stall = r_full[r_wr_half];
  assign o_err_ovf  = r_err_ovf;
  assign o_busy     = (|r_full) || !rd_idle;

  assign beat_ok = i_wr_beat && !o_wr_stall;
  assign wr_done = beat_ok && (r_wr_cnt == WR_CNT_WD'(HALF_BEATS - 1));

  // Set and clear always target different halves, so both may land in one edge.
  always_comb begin
    full_nxt = r_full;
    if (wr_done) full_nxt[r_wr_half] = 1'b1;
    if (rd_done) full_nxt[r_rd_half] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_full    <= '0;
      r_wr_half <= 1'b0;
      r_rd_half <= 1'b0;
      r_wr_cnt  <= '0;
      r_err_ovf <= 1'b0;
    end else if (i_layer_start) begin
      r_full    <= '0;
      r_wr_half <= 1'b0;
      r_rd_half <= 1'b0;
      r_wr_cnt  <= '0;
      r_err_ovf <= 1'b0;
    end else begin
      r_full <= full_nxt;
      if (beat_ok)                  r_wr_cnt  <= r_wr_cnt + WR_CNT_WD'(1);
      if (wr_done)                  r_wr_half <= ~r_wr_half;
      if (rd_done)                  r_rd_half <= ~r_rd_half;
      if (i_wr_beat && o_wr_stall)  r_err_ovf <= 1'b1;
    end
  end

  gbuf_b_rd_seq #(.RD_LAT(RD_LAT)) u_rd (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_clr       (i_layer_start),
    .i_half_full (r_full[r_rd_half]),
    .i_rd_half   (r_rd_half),
    .o_done      (rd_done),
    .o_idle      (rd_idle),
    .bus         (m_if)
  );

endmodule

// File: tb/tb_gbuf_b_pingpong_ctrl.sv
`timescale 1ns/1ps
module tb_gbuf_b_pingpong_ctrl;
  import gbuf_b_pingpong_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, ls, beat, wr_half, stall, err, busy;
  logic ls3, beat3, wr_half3, stall3, err3, busy3;

  gbuf_b_pingpong_ctrl_if bi ();
  gbuf_b_pingpong_ctrl_if bi3 ();

  gbuf_b_pingpong_ctrl #(.RD_LAT(1)) u_dut (
    .i_clk(clk), .i_rstn(rstn), .i_layer_start(ls), .i_wr_beat(beat),
    .o_wr_half(wr_half), .o_wr_stall(stall), .o_err_ovf(err), .o_busy(busy), .m_if(bi));

  gbuf_b_pingpong_ctrl #(.RD_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rstn(rstn), .i_layer_start(ls3), .i_wr_beat(beat3),
    .o_wr_half(wr_half3), .o_wr_stall(stall3), .o_err_ovf(err3), .o_busy(busy3), .m_if(bi3));

  int total = 0;
  int bad = 0;
  logic [31:0] salt = 32'h1234_5678;

  // Distinct content per (bank, half, word).
  function automatic logic [127:0] pat(int unsigned b, int unsigned h, int unsigned w);
    return {salt, 16'hB0F0, 8'(b), 8'(h), 8'(w), 8'(b * 7 + w), 16'(h * 1000 + b * 32 + w), ~salt};
  endfunction

  function automatic logic [127:0] bram_rd(logic [15:0] cs, logic [5:0] a);
    int unsigned b = 0;
    int unsigned n = 0;
    for (int unsigned i = 0; i < 16; i++) if (cs[i]) begin b = i; n++; end
    if (n != 1) return {4{32'hDEAD_BEEF}};
    return pat(b, 32'(a[5]), 32'(a[4:0]));
  endfunction

  // BRAM models: latency 1 and latency 3
  logic [127:0] d1;
  logic [127:0] d3 [3];
  always @(posedge clk) begin
    d1    <= bram_rd(bi.o_rd_cs, bi.o_rd_addr);
    d3[0] <= bram_rd(bi3.o_rd_cs, bi3.o_rd_addr);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign bi.i_rd_data  = d1;
  assign bi3.i_rd_data = d3[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: collect observations only; tasks do the comparing.
  logic [127:0] obs_q [$];
  logic [21:0]  req_q [$];
  int stab_viol = 0, idle_viol = 0, lat_viol = 0, last_en = 0;
  logic p_valid = 1'b0, p_ready = 1'b0, p_ls = 1'b0;
  logic [127:0] p_data = '0;
  always @(negedge clk) begin
    if (rstn) begin
      if (bi.o_rd_en) begin req_q.push_back({bi.o_rd_cs, bi.o_rd_addr}); last_en = cyc; end
      else if (bi.o_rd_cs !== '0 || bi.o_rd_addr !== '0) idle_viol++;
      if (bi.o_m_valid && !p_valid && (cyc - last_en) != 2) lat_viol++;
      if (p_valid && !p_ready && !p_ls && (!bi.o_m_valid || bi.o_m_data !== p_data)) stab_viol++;
      if (bi.o_m_valid && bi.i_m_ready && !ls) obs_q.push_back(bi.o_m_data);
    end
    p_valid = bi.o_m_valid; p_ready = bi.i_m_ready; p_ls = ls; p_data = bi.o_m_data;
  end

  logic [127:0] obs3_q [$];
  int stab3_viol = 0, lat3_viol = 0, lat3_rise = 0, last3_en = 0;
  logic q_valid = 1'b0, q_ready = 1'b0;
  logic [127:0] q_data = '0;
  always @(negedge clk) begin
    if (rstn) begin
      if (bi3.o_rd_en) last3_en = cyc;
      if (bi3.o_m_valid && !q_valid) begin
        lat3_rise++;
        if ((cyc - last3_en) != 4) lat3_viol++;
      end
      if (q_valid && !q_ready && (!bi3.o_m_valid || bi3.o_m_data !== q_data)) stab3_viol++;
      if (bi3.o_m_valid && bi3.i_m_ready && !ls3) obs3_q.push_back(bi3.o_m_data);
    end
    q_valid = bi3.o_m_valid; q_ready = bi3.i_m_ready; q_data = bi3.o_m_data;
  end

  // Reference model: accepted beats, expected words and read requests.
  int acc = 0, obs_base = 0, req_base = 0, rd_limit = 0;
  int stall_mis = 0, half_mis = 0;
  logic [127:0] exp_q [$];
  logic [21:0]  ereq_q [$];

  function automatic int nobs();
    return obs_q.size() - obs_base;
  endfunction

  function automatic int obs_diff();
    if (nobs() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (obs_q[obs_base + i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic int req_diff();
    if (req_q.size() - req_base != ereq_q.size()) return -2;
    foreach (ereq_q[i]) if (req_q[req_base + i] !== ereq_q[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_cycle(input bit want, input int rmode);
    int written, drained, h;
    bit exp_stall;
    written   = acc / 512;
    drained   = nobs() / 512;
    exp_stall = (written - drained) >= 2;
    if (stall !== exp_stall) stall_mis++;
    if (wr_half !== written[0]) half_mis++;
    beat = want && !exp_stall;
    case (rmode)
      0: bi.i_m_ready = 1'b0;
      1: bi.i_m_ready = 1'b1;
      2: bi.i_m_ready = ~bi.i_m_ready;
      3: bi.i_m_ready = 1'($urandom % 2);
      default: bi.i_m_ready = (nobs() < rd_limit);
    endcase
    if (beat) begin
      acc++;
      if (acc % 512 == 0) begin
        h = ((acc - 1) / 512) % 2;
        for (int unsigned b = 0; b < 16; b++)
          for (int unsigned w = 0; w < 32; w++) begin
            exp_q.push_back(pat(b, h, w));
            ereq_q.push_back({16'(1) << b, 1'(h), 5'(w)});
          end
      end
    end
    tick();
    beat = 1'b0;
  endtask

  task automatic pulse_ls();
    ls = 1'b1; beat = 1'b0; bi.i_m_ready = 1'b0;
    tick();
    ls = 1'b0;
    acc = 0; exp_q.delete(); ereq_q.delete();
    obs_base = obs_q.size(); req_base = req_q.size();
    stall_mis = 0; half_mis = 0;
    salt = $urandom;
  endtask

  task automatic test_reset();
    rstn = 1'b0; ls = 1'b0; beat = 1'b0; bi.i_m_ready = 1'b0;
    ls3 = 1'b0; beat3 = 1'b0; bi3.i_m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (wr_half !== 1'b0)      begin bad++; $display("FAIL reset.wr_half got=%b want=0", wr_half); end
    total++; if (stall !== 1'b0)        begin bad++; $display("FAIL reset.stall got=%b want=0", stall); end
    total++; if (err !== 1'b0)          begin bad++; $display("FAIL reset.err got=%b want=0", err); end
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL reset.busy got=%b want=0", busy); end
    total++; if (bi.o_rd_en !== 1'b0 || bi.o_rd_cs !== '0 || bi.o_rd_addr !== '0)
      begin bad++; $display("FAIL reset.rd got=%b/%h/%h want=0/0/0", bi.o_rd_en, bi.o_rd_cs, bi.o_rd_addr); end
    total++; if (bi.o_m_valid !== 1'b0 || bi.o_m_data !== '0)
      begin bad++; $display("FAIL reset.m got=%b/%h want=0/0", bi.o_m_valid, bi.o_m_data); end
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_half();
    int g = 0, d;
    pulse_ls();
    while (acc < 512 && g < 3000) begin drive_cycle($urandom % 4 != 0, 1); g++; end
    while (nobs() < 512 && g < 5000) begin drive_cycle(0, 1); g++; end
    repeat (3) drive_cycle(0, 1);
    total++; if (g >= 5000) begin bad++; $display("FAIL single.timeout got=%0d words want=512", nobs()); end
    total++; if (wr_half !== 1'b1) begin bad++; $display("FAIL single.wr_half got=%b want=1", wr_half); end
    total++; if (req_q[req_base] !== {16'h0001, 6'd0})
      begin bad++; $display("FAIL single.first_req got=%h want=%h", req_q[req_base], {16'h0001, 6'd0}); end
    total++; if (req_q[req_q.size() - 1] !== {16'h8000, 6'd31})
      begin bad++; $display("FAIL single.last_req got=%h want=%h", req_q[req_q.size() - 1], {16'h8000, 6'd31}); end
    d = req_diff();
    total++; if (d != -1) begin bad++; $display("FAIL single.req_seq got=diff@%0d want=none", d); end
    d = obs_diff();
    total++; if (d != -1) begin bad++; $display("FAIL single.data_seq got=diff@%0d want=none", d); end
    total++; if (u_dut.r_full !== 2'b00) begin bad++; $display("FAIL single.full got=%b want=00", u_dut.r_full); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single.busy got=%b want=0", busy); end
    total++; if (stall_mis != 0 || half_mis != 0)
      begin bad++; $display("FAIL single.wr_track got=%0d/%0d want=0/0", stall_mis, half_mis); end
    total++; if (idle_viol != 0) begin bad++; $display("FAIL single.idle_addr got=%0d want=0", idle_viol); end
    total++; if (lat_viol != 0) begin bad++; $display("FAIL single.latency got=%0d want=0", lat_viol); end
  endtask

  task automatic test_overflow();
    int g = 0, d;
    pulse_ls();
    while (acc < 1024 && g < 4000) begin drive_cycle(1, 0); g++; end
    total++; if (stall !== 1'b1 || wr_half !== 1'b0 || u_dut.r_full !== 2'b11)
      begin bad++; $display("FAIL ovf.stall_state got=%b/%b/%b want=1/0/11", stall, wr_half, u_dut.r_full); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ovf.err_early got=%b want=0", err); end
    beat = 1'b1;
    tick();
    beat = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf.err got=%b want=1", err); end
    while (nobs() < 512 && g < 8000) begin drive_cycle(0, 1); g++; end
    while (acc < 1535 && g < 12000) begin drive_cycle(1, 1); g++; end
    total++; if (wr_half !== 1'b0) begin bad++; $display("FAIL ovf.beat1535_half got=%b want=0", wr_half); end
    drive_cycle(1, 1);
    total++; if (wr_half !== 1'b1) begin bad++; $display("FAIL ovf.beat1536_half got=%b want=1", wr_half); end
    while (nobs() < 1536 && g < 16000) begin drive_cycle(0, 1); g++; end
    total++; if (g >= 16000) begin bad++; $display("FAIL ovf.timeout got=%0d words want=1536", nobs()); end
    d = obs_diff();
    total++; if (d != -1) begin bad++; $display("FAIL ovf.data_seq got=diff@%0d want=none", d); end
    total++; if (stall_mis != 0 || half_mis != 0)
      begin bad++; $display("FAIL ovf.wr_track got=%0d/%0d want=0/0", stall_mis, half_mis); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf.err_sticky got=%b want=1", err); end
  endtask

  task automatic test_ready_toggle();
    int g = 0, d, sv0;
    pulse_ls();
    sv0 = stab_viol;
    while (acc < 512 && g < 3000) begin drive_cycle($urandom % 2, 2); g++; end
    while (nobs() < 512 && g < 6000) begin drive_cycle(0, (g % 200 < 100) ? 2 : 3); g++; end
    total++; if (g >= 6000) begin bad++; $display("FAIL toggle.timeout got=%0d words want=512", nobs()); end
    total++; if (stab_viol != sv0) begin bad++; $display("FAIL toggle.stable got=%0d want=0", stab_viol - sv0); end
    d = req_diff();
    total++; if (d != -1) begin bad++; $display("FAIL toggle.req_seq got=diff@%0d want=none", d); end
    d = obs_diff();
    total++; if (d != -1) begin bad++; $display("FAIL toggle.data_seq got=diff@%0d want=none", d); end
  endtask

  task automatic test_simultaneous();
    int g = 0, d;
    pulse_ls();
    while (acc < 1023 && g < 4000) begin drive_cycle(1, 0); g++; end
    rd_limit = 511;
    while (nobs() < 511 && g < 6000) begin drive_cycle(0, 4); g++; end
    while (!bi.o_m_valid && g < 6100) begin drive_cycle(0, 0); g++; end
    total++; if (u_dut.r_full !== 2'b01 || wr_half !== 1'b1)
      begin bad++; $display("FAIL simul.before got=%b/%b want=01/1", u_dut.r_full, wr_half); end
    drive_cycle(1, 1);
    total++; if (u_dut.r_full !== 2'b10 || wr_half !== 1'b0 || nobs() != 512)
      begin bad++; $display("FAIL simul.after got=%b/%b/%0d want=10/0/512", u_dut.r_full, wr_half, nobs()); end
    while (nobs() < 1024 && g < 9000) begin drive_cycle(0, 1); g++; end
    total++; if (g >= 9000) begin bad++; $display("FAIL simul.timeout got=%0d words want=1024", nobs()); end
    d = obs_diff();
    total++; if (d != -1) begin bad++; $display("FAIL simul.data_seq got=diff@%0d want=none", d); end
  endtask

  task automatic test_layer_start();
    int g = 0;
    pulse_ls();
    while (acc < 1024 && g < 4000) begin drive_cycle(1, 0); g++; end
    beat = 1'b1; tick(); beat = 1'b0;
    rd_limit = 236;
    while (nobs() < 236 && g < 6000) begin drive_cycle(0, 4); g++; end
    while (!bi.o_m_valid && g < 6100) begin drive_cycle(0, 0); g++; end
    total++; if (u_dut.u_rd.r_bank !== 4'd7 || u_dut.u_rd.r_word !== 5'd12 || err !== 1'b1)
      begin bad++; $display("FAIL ls.position got=%0d/%0d/%b want=7/12/1", u_dut.u_rd.r_bank, u_dut.u_rd.r_word, err); end
    pulse_ls();
    total++; if (bi.o_m_valid !== 1'b0) begin bad++; $display("FAIL ls.valid got=%b want=0", bi.o_m_valid); end
    total++; if (u_dut.u_rd.r_state !== RD_IDLE) begin bad++; $display("FAIL ls.fsm got=%0d want=0", u_dut.u_rd.r_state); end
    total++; if (u_dut.r_full !== 2'b00 || wr_half !== 1'b0 || u_dut.r_rd_half !== 1'b0)
      begin bad++; $display("FAIL ls.halves got=%b/%b/%b want=00/0/0", u_dut.r_full, wr_half, u_dut.r_rd_half); end
    total++; if (err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ls.err_busy got=%b/%b want=0/0", err, busy); end
  endtask

  task automatic test_lat3();
    int g = 0, n = 0, base, rise0, lv0, sv0, d = -1;
    logic [127:0] e;
    ls3 = 1'b1; tick(); ls3 = 1'b0;
    salt = $urandom;
    base = obs3_q.size(); rise0 = lat3_rise; lv0 = lat3_viol; sv0 = stab3_viol;
    while ((n < 512 || obs3_q.size() - base < 512) && g < 6000) begin
      beat3 = (n < 512) && ($urandom % 3 != 0);
      if (beat3) n++;
      bi3.i_m_ready = 1'($urandom % 2);
      tick();
      g++;
    end
    beat3 = 1'b0; bi3.i_m_ready = 1'b0;
    total++; if (g >= 6000) begin bad++; $display("FAIL lat3.timeout got=%0d words want=512", obs3_q.size() - base); end
    total++; if (lat3_rise - rise0 != 512) begin bad++; $display("FAIL lat3.valid_rises got=%0d want=512", lat3_rise - rise0); end
    total++; if (lat3_viol != lv0) begin bad++; $display("FAIL lat3.latency got=%0d want=0", lat3_viol - lv0); end
    total++; if (stab3_viol != sv0) begin bad++; $display("FAIL lat3.stable got=%0d want=0", stab3_viol - sv0); end
    for (int unsigned i = 0; i < 512 && d < 0; i++) begin
      e = pat(i / 32, 0, i % 32);
      if (obs3_q[base + i] !== e) d = i;
    end
    total++; if (d != -1) begin bad++; $display("FAIL lat3.data got=diff@%0d want=none", d); end
  endtask

  initial begin
    test_reset();
    test_single_half();
    test_overflow();
    test_ready_toggle();
    test_simultaneous();
    test_layer_start();
    test_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
